// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the 8N1 UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    // Offset from the start-bit edge to the start-bit centre, in clocks.
    function automatic int half_bit(input int clks);
        return (clks - 1) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer with configurable reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic r_ff1;
    logic r_ff2;

    // Two-stage capture of the asynchronous input; reset forces the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ff1 <= RESET_VAL;
            r_ff2 <= RESET_VAL;
        end else begin
            r_ff1 <= d_i;
            r_ff2 <= r_ff1;
        end
    end

    assign q_o = r_ff2;

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with mid-bit sampling and framing-error detect
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int                IDX_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  HALF     = CNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  LAST_BIT = IDX_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [IDX_W-1:0]     w_bit_idx_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [7:0]           r_data;
    logic [7:0]           w_data_next;
    logic                 r_valid;
    logic                 w_valid_next;
    logic                 r_frame_err;
    logic                 w_frame_err_next;
    logic                 r_busy;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_i),
        .q_o (w_rx_s)
    );

    // Next-state, bit timing and output-pulse decisions, all from the synchronized line.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt + CNT_W'(1);
        w_bit_idx_next   = r_bit_idx;
        w_shift_next     = r_shift;
        w_data_next      = r_data;
        w_valid_next     = 1'b0;
        w_frame_err_next = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (!w_rx_s) begin
                    w_state_next = START;
                end
            end
            START: begin
                // A start bit that is high again at its centre was only a glitch.
                if (r_cnt == HALF) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next   = DATA;
                        w_bit_idx_next = '0;
                    end
                end
            end
            DATA: begin
                if (r_cnt == LAST) begin
                    w_cnt_next              = '0;
                    w_shift_next[r_bit_idx] = w_rx_s;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                // Leaving at the stop-bit centre keeps back-to-back start bits catchable.
                if (r_cnt == LAST) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low (break) line must not look like a fresh start bit.
                w_cnt_next = '0;
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    // State, datapath and registered output updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_frame_err_next;
            r_busy      <= (w_state_next != IDLE);
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frame_err;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - directed self-checking bench for uart_rx_byte
module tb_uart_rx_byte;

    localparam int C   = 16;
    localparam int LAT = 155;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       busy_o;

    always #5 clk = ~clk;

    uart_rx_byte #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_valid = 0;
    int         n_ferr = 0;
    int         last_valid_cyc = 0;
    int         last_ferr_cyc = 0;
    logic [7:0] last_data = '0;
    int         wide = 0;
    int         both = 0;
    int         unstable = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ferr = 1'b0;
    logic       prev_rst = 1'b1;
    logic [7:0] prev_data;
    int         vq_cyc[$];
    logic [7:0] vq_data[$];

    // Pulse bookkeeping and protocol invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
            last_data      <= data_o;
            vq_cyc.push_back(cyc);
            vq_data.push_back(data_o);
            if (prev_valid) wide <= wide + 1;
        end
        if (frame_err_o === 1'b1) begin
            n_ferr        <= n_ferr + 1;
            last_ferr_cyc <= cyc;
            if (prev_ferr) wide <= wide + 1;
        end
        if (valid_o === 1'b1 && frame_err_o === 1'b1) both <= both + 1;
        if (data_o !== prev_data && valid_o !== 1'b1 && !rst && !prev_rst) unstable <= unstable + 1;
        prev_valid <= (valid_o === 1'b1);
        prev_ferr  <= (frame_err_o === 1'b1);
        prev_rst   <= rst;
        prev_data  <= data_o;
    end

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
        return c;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Called #1 after a clock edge; returns at the same phase, line left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int start_cyc);
        rx_i = 1'b0;
        start_cyc = cyc;
        repeat (C) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (C) @(posedge clk);
            #1;
        end
        rx_i = stop;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_data;
        logic [7:0] exp_upper;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int st, st0, nv, nf, k;
        logic [7:0] d;

        vecs[0] = '{8'h61, 8'h61, 8'h41};
        vecs[1] = '{8'h00, 8'h00, 8'h00};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF};
        vecs[3] = '{8'hA5, 8'hA5, 8'hA5};
        vecs[4] = '{8'h7A, 8'h7A, 8'h5A};

        // Reset state
        rst  = 1'b1;
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data", data_o, 0);
        check("reset_valid", valid_o, 0);
        check("reset_ferr", frame_err_o, 0);
        check("reset_busy", busy_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);

        // Table-driven nominal frames
        for (int i = 0; i < 5; i++) begin
            nv = n_valid;
            send_frame(vecs[i].data, 1'b1, st);
            idle(20);
            check($sformatf("vec%0d_count", i), n_valid - nv, 1);
            check($sformatf("vec%0d_data", i), last_data, vecs[i].exp_data);
            check($sformatf("vec%0d_upper", i), to_upper(last_data), vecs[i].exp_upper);
            check($sformatf("vec%0d_latency", i), last_valid_cyc - st, LAT);
        end

        // Start-bit glitch
        nv = n_valid;
        nf = n_ferr;
        rx_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_i = 1'b1;
        check("glitch_busy_seen", busy_o, 1);
        k = 0;
        while (k < 12) begin
            @(negedge clk);
            if (!busy_o) break;
            k++;
        end
        check("glitch_busy_clear", (k <= 10), 1);
        @(posedge clk);
        #1;
        idle(10);
        check("glitch_no_valid", n_valid - nv, 0);
        check("glitch_no_ferr", n_ferr - nf, 0);
        send_frame(8'h7A, 1'b1, st);
        idle(20);
        check("glitch_next_data", last_data, 8'h7A);
        check("glitch_next_count", n_valid - nv, 1);

        // Framing error followed by a held-low line
        nv = n_valid;
        nf = n_ferr;
        d  = data_o;
        send_frame(8'h48, 1'b0, st);
        repeat (3 * C) @(posedge clk);
        #1;
        check("ferr_count", n_ferr - nf, 1);
        check("ferr_latency", last_ferr_cyc - st, LAT);
        check("ferr_no_valid", n_valid - nv, 0);
        check("ferr_data_held", data_o, d);
        check("ferr_wait_busy", busy_o, 1);
        idle(20);
        check("ferr_released", busy_o, 0);
        check("ferr_no_restart", n_ferr - nf, 1);
        send_frame(8'h20, 1'b1, st);
        idle(20);
        check("ferr_next_data", last_data, 8'h20);
        check("ferr_next_count", n_valid - nv, 1);

        // Back-to-back frames with no idle gap
        vq_cyc.delete();
        vq_data.delete();
        send_frame(8'h48, 1'b1, st0);
        send_frame(8'hB7, 1'b1, st);
        send_frame(8'h7B, 1'b1, st);
        idle(20);
        check("b2b_count", vq_cyc.size(), 3);
        if (vq_cyc.size() == 3) begin
            check("b2b_first_latency", vq_cyc[0] - st0, LAT);
            check("b2b_gap01", vq_cyc[1] - vq_cyc[0], 160);
            check("b2b_gap12", vq_cyc[2] - vq_cyc[1], 160);
            check("b2b_data0", vq_data[0], 8'h48);
            check("b2b_data1", vq_data[1], 8'hB7);
            check("b2b_data2", vq_data[2], 8'h7B);
        end

        // Reset during data bit 3 of 0xFF
        nv = n_valid;
        rx_i = 1'b0;
        repeat (C) @(posedge clk);
        #1;
        rx_i = 1'b1;
        repeat (3 * C + 8) @(posedge clk);
        #1;
        check("midrst_busy_before", busy_o, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_data", data_o, 0);
        check("midrst_valid", valid_o, 0);
        check("midrst_ferr", frame_err_o, 0);
        check("midrst_busy", busy_o, 0);
        idle(7 * C);
        check("midrst_no_pulse", n_valid - nv, 0);
        check("midrst_idle", busy_o, 0);
        send_frame(8'h6D, 1'b1, st);
        idle(20);
        check("midrst_next_data", last_data, 8'h6D);
        check("midrst_next_upper", to_upper(data_o), 8'h4D);
        check("midrst_next_latency", last_valid_cyc - st, LAT);

        // Invariants over the whole run
        check("pulse_width_one", wide, 0);
        check("valid_ferr_exclusive", both, 0);
        check("data_stable", unstable, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
8N1 UART receiver that deserialises an asynchronous serial line into bytes for the character-processing path. It sits directly upstream of the toUpper case-conversion stage: data_o drives toUpper's 8-bit in, and valid_o marks each new character. The block is fully synchronous to one clock, uses a 2-flop input synchronizer and samples each bit at mid-bit. It reports framing errors and rejects start-bit glitches.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 4. Use 868 for 100 MHz / 115200 baud.
DATA_BITS, 8, data bits per frame; fixed at 8 for this design.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
rx_i  input  1  asynchronous serial line; idles high.
data_o  output  8  last correctly received byte; feeds toUpper in.
valid_o  output  1  one-cycle pulse when data_o is updated.
frame_err_o  output  1  one-cycle pulse when the stop bit samples low.
busy_o  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset is synchronous and active-high. While rst=1: state=IDLE, both synchronizer flops=1, data_o=0, valid_o=0, frame_err_o=0, busy_o=0, and the counter and bit index are 0. Reset asserted mid-frame discards the partial byte; no pulse is generated.
- Synchronizer: rx_i -> ff1 -> ff2. rx_s = ff2. All FSM decisions use rx_s only.
- HALF = (CLKS_PER_BIT-1)/2, using integer division. Counter width = $clog2(CLKS_PER_BIT).
- IDLE: if rx_s=0, go to START with cnt=0.
- START: lasts HALF+1 cycles (cnt 0..HALF); rx_s is sampled at cnt=HALF.
  - If rx_s=0: go to DATA with cnt=0, bit_idx=0.
  - If rx_s=1: treat as a glitch, return to IDLE, no pulse.
- DATA: each bit lasts CLKS_PER_BIT cycles; rx_s is sampled at cnt=CLKS_PER_BIT-1.
  - Bits arrive LSB first; store the sample in shift[bit_idx].
  - After bit_idx=7 is sampled, go to STOP.
- STOP: lasts CLKS_PER_BIT cycles; rx_s is sampled at cnt=CLKS_PER_BIT-1.
  - If rx_s=1: data_o<=shift, valid_o=1 for exactly one cycle, go to IDLE.
  - If rx_s=0: frame_err_o=1 for one cycle, data_o holds its old value, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition from retriggering a start.
- Latency: let T0 be the clk edge at which ff1 first captures a low start bit. valid_o is high in the cycle beginning at edge T0 + 3 + HALF + 9*CLKS_PER_BIT. For CLKS_PER_BIT=16 this is T0+154, with zero tolerance.
- Back-to-back frames: a start bit that immediately follows the stop bit, with no idle time, must be received. The FSM returns to IDLE at the stop-bit centre, before the next falling edge reaches rx_s.
- valid_o and frame_err_o are never high in the same cycle.
- data_o is stable between valid_o pulses.
- busy_o = (state != IDLE), registered with the state.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, WAIT_HIGH}
  - localparam DATA_BITS=8
  - localparam DEFAULT_CLKS_PER_BIT=16
  - function half_bit(clks) returning (clks-1)/2
- One sub-module: sync_2ff, a 1-bit two-flop synchronizer with a reset value parameter; instantiate it with reset value 1.
- The FSM, counter and shift register stay in uart_rx_byte.

Test Plan:
- Nominal byte: CLKS_PER_BIT=16, send frame 0x61 -> valid_o pulses at T0+154, data_o=0x61, and the downstream toUpper out reads 0x41.
- Glitch rejection: rx_i low for 4 cycles, then high -> no valid_o and no frame_err_o; busy_o returns to 0 within 10 cycles; a following 0x7A frame gives data_o=0x7A.
- Framing error: send 0x48 with stop bit=0, holding rx_i low for 3 more bit-times -> frame_err_o pulses once, data_o unchanged, no restart while low; after the line goes high, 0x20 is received correctly.
- Back-to-back: frames 0x48, 0xB7, 0x7B with no idle gap -> three valid_o pulses exactly 160 cycles apart, with data 0x48, 0xB7, 0x7B.
- Reset mid-frame: assert rst for 1 cycle during data bit 3 of 0xFF -> all outputs 0, no pulse; the next frame 0x6D yields data_o=0x6D (toUpper out 0x4D).
- Boundary values: frames 0x00 and 0xFF -> data_o 0x00 and 0xFF, with each valid_o exactly one cycle wide.
